nios_pio_ext: RTL and testbench
===============================

# nios_pio_ext

Parametrised Avalon-MM parallel I/O slave for the Nios subsystem: WIDTH bidirectional pins with per-bit direction, atomic set/clear of outputs, synchronised inputs, per-bit edge capture and a maskable interrupt. Sits on the Nios data master beside the existing fixed 32-bit output-only PIO and supersedes it for new GPIO/handshake lines; programmed through eight word addresses.

## Interface
- WIDTH, 32, pin count, 1..32; register bits above WIDTH-1 read 0, writes ignored.
- SYNC_STAGES, 2, input synchroniser depth, 2..4.
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- IRQ_MODE, 0, 0 edge (from capture register), 1 level (from synchronised input).
- RESET_OUT, 0, reset value of output register (WIDTH bits).
- RESET_DIR, 0, reset value of direction register (1 = output).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears/loads every register immediately.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write; write strobe = chipselect & ~write_n.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output register value.
- oe_port  out  WIDTH  direction register (pad output-enable).
- irq  out  1  interrupt, active-high.

## Operation
- Register map (address: read / write):
  - 0 DATA: per bit dir ? out : sync_in / out <= wdata.
  - 1 DIR: dir / dir <= wdata.
  - 2 IRQMASK: mask / mask <= wdata.
  - 3 EDGECAP: cap / cap <= cap & ~wdata (write-1-to-clear).
  - 4 OUTSET: 0 / out <= out | wdata.
  - 5 OUTCLR: 0 / out <= out & ~wdata.
  - 6, 7: read 0 / writes ignored.
- Input path: SYNC_STAGES flops then one history flop prev; edge = sync&~prev (0), ~sync&prev (1), sync^prev (2).
- Capture: cap[i] <= edge[i] | (cap[i] & ~clr[i]); a new edge in the same cycle as its clear wins (bit stays 1).
- Capture runs for every bit regardless of DIR; only the mask gates irq.
- irq = |(cap & mask) for IRQ_MODE 0; |(sync_in & mask) for IRQ_MODE 1. Derived combinationally from registers only; no pin-to-irq combinational path.
- readdata updated every clock from address regardless of chipselect (no read strobe, reads have no side effects).
- Reset values: out_port = RESET_OUT, oe_port = RESET_DIR, mask 0, cap 0, synchroniser and prev 0, readdata 0, irq 0.
- prev reset to 0: with EDGE_TYPE 0/2, an input held high through reset produces one capture once the synchroniser fills; software clears it after init.

## Timing
- Write at edge N: out_port/oe_port/mask/cap reflect it after edge N (visible cycle N+1).
- Read: address presented before edge N, readdata valid after edge N (1-cycle latency, fixed).
- Pin change settled before edge N: sync_in updated after edge N+SYNC_STAGES-1; cap bit and irq (edge mode) set after edge N+SYNC_STAGES; level-mode irq after edge N+SYNC_STAGES-1.
- DATA read of an input bit reflects the pin SYNC_STAGES+1 cycles after the change (sync + readdata register).
- Reset asserted mid-write: the write is lost; all state per reset values while reset high and on the first edge after release.
- Pulses shorter than one clk period may be missed; no requirement.

## Structure
- Package nios_pio_pkg: address constants ADDR_DATA..ADDR_OUTCLR (3-bit), EDGE_RISE/FALL/ANY codes, IRQ_EDGE/IRQ_LEVEL codes.
- Sub-module pio_sync_edge: WIDTH/SYNC_STAGES/EDGE_TYPE parameters, in_port -> sync_in, edge vectors; clk/reset shared.
- Top holds register file, capture logic, read mux, irq reduction.

## Test plan
- Reset with RESET_OUT=0x0000_00A5, RESET_DIR=0x0000_00FF -> out_port 0xA5, oe_port 0xFF, readdata 0, irq 0; read addr 1 -> 0x0000_00FF one cycle later.
- Write 0xF0 to addr 0, then 0x0F to addr 4, then 0x30 to addr 5 -> out_port 0xF0, 0xFF, 0xCF on successive cycles after each write.
- DIR=0x0F, out=0x05, in_port=0xA0 (held 4 cycles) -> DATA read 0x0000_00A5; WIDTH=8 build reads upper 24 bits 0.
- EDGE_TYPE 0, mask=0x01, in_port[0] 0->1 -> cap bit0 and irq high exactly SYNC_STAGES cycles after change; write 0x01 to addr 3 -> irq low next cycle; falling edge sets nothing.
- Clear of cap[2] in same cycle as new rising edge on bit 2 -> cap[2] remains 1, irq stays high if masked.
- Assert reset for 1 cycle while cap=0xFF, mask=0xFF -> cap, mask, irq 0 immediately (asynchronously), outputs return to reset values.

Source files
------------

// File: rtl/nios_pio_pkg.sv
// Shared constants for the nios_pio_ext parallel I/O slave: register
// addresses, edge-capture selection codes and interrupt mode codes.
package nios_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_EDGE  = 0;
    localparam int IRQ_LEVEL = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser and edge detector for the PIO pins. The history flop
// resets to 0, so a pin held high through reset shows up as one rising
// edge once the synchroniser has filled.
module pio_sync_edge
    import nios_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Shift pins through the synchroniser; prev keeps last cycle's synced value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Select which transition of the synchronised input counts as an edge.
    always_comb begin
        edge_det = sync_in & ~prev_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_det = ~sync_in & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_det = sync_in ^ prev_q;
        end
    end

endmodule

// File: rtl/nios_pio_ext.sv
// Avalon-MM parallel I/O slave: per-bit direction, atomic set/clear of the
// output register, synchronised inputs, write-1-to-clear edge capture and a
// maskable interrupt. Read data is registered with a fixed one-cycle latency.
module nios_pio_ext
    import nios_pio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          IRQ_MODE    = IRQ_EDGE,
    parameter logic [31:0] RESET_OUT   = 32'h0,
    parameter logic [31:0] RESET_DIR   = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic             wr_en;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .sync_in  (sync_in),
        .edge_det (edge_det)
    );

    assign wr_en    = chipselect & ~write_n;
    assign wdata    = writedata[WIDTH-1:0];
    assign out_port = out_q;
    assign oe_port  = dir_q;
    assign readdata = rdata_q;

    // Interrupt comes only from registers so pins never reach irq combinationally.
    assign irq = (IRQ_MODE == IRQ_LEVEL) ? |(sync_in & mask_q) : |(cap_q & mask_q);

    // Register writes, capture update (a fresh edge beats its own clear) and read mux.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        clr     = '0;
        rdata_d = 32'h0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:    out_d  = wdata;
                ADDR_DIR:     dir_d  = wdata;
                ADDR_IRQMASK: mask_d = wdata;
                ADDR_EDGECAP: clr    = wdata;
                ADDR_OUTSET:  out_d  = out_q | wdata;
                ADDR_OUTCLR:  out_d  = out_q & ~wdata;
                default: ;
            endcase
        end
        cap_d = edge_det | (cap_q & ~clr);
        case (address)
            ADDR_DATA:    rdata_d = 32'((dir_q & out_q) | (~dir_q & sync_in));
            ADDR_DIR:     rdata_d = 32'(dir_q);
            ADDR_IRQMASK: rdata_d = 32'(mask_q);
            ADDR_EDGECAP: rdata_d = 32'(cap_q);
            default:      rdata_d = 32'h0;
        endcase
    end

    // Register file state and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= RESET_OUT[WIDTH-1:0];
            dir_q   <= RESET_DIR[WIDTH-1:0];
            mask_q  <= '0;
            cap_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_nios_pio_ext.sv
// Directed bench for nios_pio_ext (8-bit build, 2-stage sync, rising-edge
// capture, edge-mode irq) with a register-level reference model.
module tb_nios_pio_ext;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   address = 3'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'h0;
    logic [31:0]  readdata;
    logic [W-1:0] in_port = '0;
    logic [W-1:0] out_port;
    logic [W-1:0] oe_port;
    logic         irq;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    nios_pio_ext #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .EDGE_TYPE   (0),
        .IRQ_MODE    (0),
        .RESET_OUT   (32'h0000_00A5),
        .RESET_DIR   (32'h0000_00FF)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe_port    (oe_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: register contents as software sees them.
    logic [W-1:0]  m_out, m_dir, m_mask, m_cap, m_sync, m_prev;
    logic [31:0]   m_rd;
    logic [W-1:0]  samples[$];
    logic [W-1:0]  t_rise, t_clr, t_wd;

    function automatic void model_reset();
        m_out  = 8'hA5;
        m_dir  = 8'hFF;
        m_mask = '0;
        m_cap  = '0;
        m_sync = '0;
        m_prev = '0;
        m_rd   = 32'h0;
        samples = {};
        for (int i = 0; i < S; i++) samples.push_back('0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            // the synchronised value rose during the previous cycle
            t_rise = m_sync & ~m_prev;
            t_clr  = '0;
            t_wd   = writedata[W-1:0];
            case (address)
                3'd0:    m_rd = {24'h0, (m_dir & m_out) | (~m_dir & m_sync)};
                3'd1:    m_rd = {24'h0, m_dir};
                3'd2:    m_rd = {24'h0, m_mask};
                3'd3:    m_rd = {24'h0, m_cap};
                default: m_rd = 32'h0;
            endcase
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_out = t_wd;
                    3'd1: m_dir = t_wd;
                    3'd2: m_mask = t_wd;
                    3'd3: t_clr = t_wd;
                    3'd4: m_out = m_out | t_wd;
                    3'd5: m_out = m_out & ~t_wd;
                    default: ;
                endcase
            end
            m_cap  = t_rise | (m_cap & ~t_clr);
            m_prev = m_sync;
            // synchronised input is the pin value sampled S-1 clock edges ago
            samples.push_back(in_port);
            void'(samples.pop_front());
            m_sync = samples[0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_out_port", {24'h0, out_port}, {24'h0, m_out});
            check("mdl_oe_port",  {24'h0, oe_port},  {24'h0, m_dir});
            check("mdl_irq",      {31'h0, irq},      {31'h0, |(m_cap & m_mask)});
            check("mdl_readdata", readdata,          m_rd);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        check(name, readdata, exp);
    endtask

    task automatic set_pins(input logic [W-1:0] v, input int settle);
        @(negedge clk);
        in_port = v;
        repeat (settle) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_port", {24'h0, out_port}, 32'h0000_00A5);
        check("rst_oe_port",  {24'h0, oe_port},  32'h0000_00FF);
        check("rst_readdata", readdata,          32'h0);
        check("rst_irq",      {31'h0, irq},      32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(3'd1, 32'h0000_00FF, "rd_dir_reset");

        wr(3'd0, 32'h0000_00F0);
        check("wr_data",   {24'h0, out_port}, 32'h0000_00F0);
        wr(3'd4, 32'h0000_000F);
        check("wr_outset", {24'h0, out_port}, 32'h0000_00FF);
        wr(3'd5, 32'h0000_0030);
        check("wr_outclr", {24'h0, out_port}, 32'h0000_00CF);

        wr(3'd1, 32'h0000_000F);
        wr(3'd0, 32'h0000_0005);
        set_pins(8'hA0, 4);
        rd(3'd0, 32'h0000_00A5, "rd_data_mixed");
        wr(3'd1, 32'hFFFF_FFFF);
        rd(3'd1, 32'h0000_00FF, "rd_dir_upper_zero");
        rd(3'd3, 32'h0000_00A0, "cap_after_a0");
        wr(3'd3, 32'h0000_00FF);
        rd(3'd3, 32'h0, "cap_cleared");
        set_pins(8'h00, 4);
        rd(3'd3, 32'h0, "falling_no_cap");

        wr(3'd2, 32'h0000_0001);
        @(negedge clk);
        in_port = 8'h01;
        @(posedge clk); #1;
        check("irq_edge_n",   {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_edge_n1",  {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_edge_n2",  {31'h0, irq}, 32'h1);
        rd(3'd3, 32'h0000_0001, "cap_bit0");
        wr(3'd3, 32'h0000_0001);
        check("irq_w1c",      {31'h0, irq}, 32'h0);
        set_pins(8'h00, 4);
        check("irq_fall_none", {31'h0, irq}, 32'h0);

        wr(3'd2, 32'h0000_0004);
        @(negedge clk);
        in_port = 8'h04;
        repeat (3) @(posedge clk);
        #1;
        check("irq_bit2",     {31'h0, irq}, 32'h1);
        set_pins(8'h00, 4);
        in_port = 8'h04;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd3;
        writedata  = 32'h0000_0004;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("clr_vs_edge_irq", {31'h0, irq}, 32'h1);
        rd(3'd3, 32'h0000_0004, "clr_vs_edge_cap");
        wr(3'd3, 32'h0000_0004);
        check("plain_clr_irq", {31'h0, irq}, 32'h0);

        wr(3'd2, 32'h0000_00FF);
        set_pins(8'h00, 4);
        set_pins(8'hFF, 4);
        rd(3'd3, 32'h0000_00FF, "cap_all");
        wr(3'd0, 32'h0000_003C);
        check("irq_all",      {31'h0, irq}, 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_irq",      {31'h0, irq},      32'h0);
        check("arst_out_port", {24'h0, out_port}, 32'h0000_00A5);
        check("arst_oe_port",  {24'h0, oe_port},  32'h0000_00FF);
        check("arst_readdata", readdata,          32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(3'd2, 32'h0, "mask_after_rst");
        repeat (4) @(negedge clk);
        rd(3'd3, 32'h0000_00FF, "cap_held_high_rst");
        check("irq_masked_rst", {31'h0, irq}, 32'h0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
